video_timing_gen_prog: RTL and testbench

- Runtime-programmable video timing generator. Successor to the fixed-parameter timing logic inside the HDMI controller.
- Generates hsync/vsync/de, pixel coordinates and a scaled framebuffer read address for the ADV7511 data path.
- Timing, sync polarity and frame scale are loaded from config inputs. A new config takes effect only at a frame boundary, so the sink never sees a torn frame.

---
 rtl/video_timing_gen_prog_if.sv | 22 ++
 rtl/video_timing_gen_prog.sv | 139 +++++++++++++
 tb/tb_video_timing_gen_prog.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_prog_if.sv
// video_timing_gen_prog_if: config bus of the programmable video timing generator
interface video_timing_gen_prog_if #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 11,
    parameter int SCALE_BITS = 2
);
    logic [H_BITS-1:0] h_active, h_fp, h_sync, h_bp;
    logic [V_BITS-1:0] v_active, v_fp, v_sync, v_bp;
    logic hs_pol, vs_pol;
    logic [SCALE_BITS-1:0] x_scale, y_scale;
    logic load, err, pending;
    modport master (
        output h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
        output hs_pol, vs_pol, x_scale, y_scale, load,
        input  err, pending
    );
    modport slave (
        input  h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp,
        input  hs_pol, vs_pol, x_scale, y_scale, load,
        output err, pending
    );
endinterface

// File: rtl/video_timing_gen_prog.sv
// video_timing_gen_prog: programmable hsync/vsync/de timing with scaled framebuffer addressing
// Config loads are staged and committed only at a frame boundary or while disabled.
module video_timing_gen_prog #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 11,
    parameter int ADDR_BITS = 19,
    parameter int SCALE_BITS = 2,
    parameter int DEF_H_ACTIVE = 640,
    parameter int DEF_H_FP = 16,
    parameter int DEF_H_SYNC = 96,
    parameter int DEF_H_BP = 48,
    parameter int DEF_V_ACTIVE = 480,
    parameter int DEF_V_FP = 11,
    parameter int DEF_V_SYNC = 2,
    parameter int DEF_V_BP = 31,
    parameter bit DEF_HS_POL = 1'b0,
    parameter bit DEF_VS_POL = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    video_timing_gen_prog_if.slave cfg,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic [H_BITS-1:0]      x_o,
    output logic [V_BITS-1:0]      y_o,
    output logic [ADDR_BITS-1:0]   fb_addr_o,
    output logic                   frame_start_o,
    output logic                   line_start_o
);
    typedef struct packed {
        logic [H_BITS-1:0] ha, hfp, hs, hbp;
        logic [V_BITS-1:0] va, vfp, vs, vbp;
        logic hpol, vpol;
        logic [SCALE_BITS-1:0] xs, ys;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{
        ha: H_BITS'(DEF_H_ACTIVE), hfp: H_BITS'(DEF_H_FP), hs: H_BITS'(DEF_H_SYNC), hbp: H_BITS'(DEF_H_BP),
        va: V_BITS'(DEF_V_ACTIVE), vfp: V_BITS'(DEF_V_FP), vs: V_BITS'(DEF_V_SYNC), vbp: V_BITS'(DEF_V_BP),
        hpol: DEF_HS_POL, vpol: DEF_VS_POL, xs: '0, ys: '0};
    localparam int AW = H_BITS + V_BITS;
    localparam logic [AW-1:0] AREA_MAX = AW'(1) << ADDR_BITS;

    cfg_t sh, pd, in_cfg;
    logic pend, err, bad, apply;
    logic [H_BITS-1:0] h, hs_beg, hs_end, h_last, x_mask;
    logic [V_BITS-1:0] v, vs_beg, vs_end, v_last, y_mask;
    logic [AW-1:0] area;
    logic [ADDR_BITS-1:0] row_w, row_base, addr;
    logic line_end, frame_end, act, act_end, x_tick, y_tick, run_act;

    assign in_cfg = {cfg.h_active, cfg.h_fp, cfg.h_sync, cfg.h_bp, cfg.v_active, cfg.v_fp,
                     cfg.v_sync, cfg.v_bp, cfg.hs_pol, cfg.vs_pol, cfg.x_scale, cfg.y_scale};
    assign area = AW'(in_cfg.ha >> in_cfg.xs) * AW'(in_cfg.va >> in_cfg.ys);
    assign bad = in_cfg.ha == '0 || in_cfg.hs == '0 || in_cfg.va == '0 || in_cfg.vs == '0 || area > AREA_MAX;
    assign apply = pend && (!en_i || frame_end);
    assign cfg.err = err;
    assign cfg.pending = pend;

    assign hs_beg = sh.ha + sh.hfp;
    assign hs_end = hs_beg + sh.hs;
    assign h_last = hs_end + sh.hbp - H_BITS'(1);
    assign vs_beg = sh.va + sh.vfp;
    assign vs_end = vs_beg + sh.vs;
    assign v_last = vs_end + sh.vbp - V_BITS'(1);
    assign line_end = h == h_last;
    assign frame_end = line_end && v == v_last;
    assign act = h < sh.ha && v < sh.va;
    assign act_end = act && h == sh.ha - H_BITS'(1);
    assign run_act = en_i && act;

    // Scale masks select the low xs/ys bits; a wrap of those bits marks a new source pixel/row.
    assign x_mask = ~(~H_BITS'(0) << sh.xs);
    assign y_mask = ~(~V_BITS'(0) << sh.ys);
    assign x_tick = ((h + H_BITS'(1)) & x_mask) == '0;
    assign y_tick = ((v + V_BITS'(1)) & y_mask) == '0;
    assign row_w = ADDR_BITS'(sh.ha >> sh.xs);

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            sh <= DEF_CFG;
            pd <= DEF_CFG;
            pend <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= cfg.load && bad;
            if (apply) begin
                sh <= pd;
                pend <= 1'b0;
            end
            if (cfg.load && !bad) begin
                pd <= in_cfg;
                pend <= 1'b1;
            end
        end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            h <= '0;
            v <= '0;
            row_base <= '0;
            addr <= '0;
        end else if (!en_i || frame_end) begin
            h <= '0;
            v <= '0;
            row_base <= '0;
            addr <= '0;
        end else begin
            h <= line_end ? '0 : h + H_BITS'(1);
            if (line_end) v <= v + V_BITS'(1);
            if (act_end) begin
                row_base <= y_tick ? row_base + row_w : row_base;
                addr <= y_tick ? row_base + row_w : row_base;
            end else if (act && x_tick) addr <= addr + ADDR_BITS'(1);
        end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            hsync_o <= ~DEF_HS_POL;
            vsync_o <= ~DEF_VS_POL;
            de_o <= 1'b0;
            x_o <= '0;
            y_o <= '0;
            fb_addr_o <= '0;
            frame_start_o <= 1'b0;
            line_start_o <= 1'b0;
        end else begin
            hsync_o <= (en_i && h >= hs_beg && h < hs_end) ? sh.hpol : ~sh.hpol;
            vsync_o <= (en_i && v >= vs_beg && v < vs_end) ? sh.vpol : ~sh.vpol;
            de_o <= run_act;
            x_o <= run_act ? h : '0;
            y_o <= run_act ? v : '0;
            fb_addr_o <= run_act ? addr : '0;
            frame_start_o <= en_i && h == '0 && v == '0;
            line_start_o <= en_i && h == '0;
        end
endmodule

// File: tb/tb_video_timing_gen_prog.sv
// tb_video_timing_gen_prog: directed scenarios for the programmable video timing generator
module tb_video_timing_gen_prog;
    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, xs, ys;
    } cfg_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic hsync, vsync, de, fs, ls;
    logic [11:0] x;
    logic [10:0] y;
    logic [18:0] fb;
    logic [46:0] got;
    int tests = 0, fails = 0;

    cfg_t DEF = '{640, 16, 96, 48, 480, 11, 2, 31, 0, 0, 0, 0};
    cfg_t A   = '{10, 2, 3, 1, 5, 1, 2, 2, 0, 0, 0, 0};
    cfg_t B   = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 0, 1, 1};
    cfg_t D   = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1, 0, 0};

    video_timing_gen_prog_if cfg_if ();

    video_timing_gen_prog dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .cfg(cfg_if.slave),
        .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .x_o(x), .y_o(y), .fb_addr_o(fb),
        .frame_start_o(fs), .line_start_o(ls)
    );

    always #5 clk = ~clk;
    assign got = {fs, ls, de, hsync, vsync, x, y, fb};

    task automatic drive_cfg(input cfg_t c);
        cfg_if.h_active = 12'(c.ha);
        cfg_if.h_fp = 12'(c.hfp);
        cfg_if.h_sync = 12'(c.hs);
        cfg_if.h_bp = 12'(c.hbp);
        cfg_if.v_active = 11'(c.va);
        cfg_if.v_fp = 11'(c.vfp);
        cfg_if.v_sync = 11'(c.vs);
        cfg_if.v_bp = 11'(c.vbp);
        cfg_if.hs_pol = 1'(c.hpol);
        cfg_if.vs_pol = 1'(c.vpol);
        cfg_if.x_scale = 2'(c.xs);
        cfg_if.y_scale = 2'(c.ys);
    endtask

    // Reference decode of one (h, v) position: {fs, ls, de, hsync, vsync, x, y, addr}
    function automatic logic [46:0] exp_out(input cfg_t c, input int hh, input int vv);
        logic d, hsy, vsy;
        int aa;
        d = hh < c.ha && vv < c.va;
        hsy = (hh >= c.ha + c.hfp && hh < c.ha + c.hfp + c.hs) ? 1'(c.hpol) : !1'(c.hpol);
        vsy = (vv >= c.va + c.vfp && vv < c.va + c.vfp + c.vs) ? 1'(c.vpol) : !1'(c.vpol);
        aa = d ? (vv >> c.ys) * (c.ha >> c.xs) + (hh >> c.xs) : 0;
        return {hh == 0 && vv == 0, hh == 0, d, hsy, vsy, d ? 12'(hh) : 12'd0, d ? 11'(vv) : 11'd0, 19'(aa)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        cfg_if.load = 1'b0;
        drive_cfg(DEF);
        repeat (3) @(negedge clk);
        tests++;
        if (got !== {5'b00011, 42'd0}) begin
            fails++;
            $display("FAIL reset_outputs got %h want %h", got, {5'b00011, 42'd0});
        end
        tests++;
        if ({cfg_if.err, cfg_if.pending} !== 2'b00) begin
            fails++;
            $display("FAIL reset_err_pending got %b want 00", {cfg_if.err, cfg_if.pending});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (got !== {5'b00011, 42'd0}) begin
            fails++;
            $display("FAIL idle_disabled got %h want %h", got, {5'b00011, 42'd0});
        end
    endtask

    task automatic test_default();
        int de_n = 0, hs_n = 0, ls_n = 0;
        logic [46:0] e;
        en = 1'b1;
        for (int k = 0; k < 2400; k++) begin
            @(negedge clk);
            e = exp_out(DEF, k % 800, k / 800);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL default_k%0d got %h want %h", k, got, e);
            end
            de_n += de ? 1 : 0;
            hs_n += hsync ? 0 : 1;
            ls_n += ls ? 1 : 0;
        end
        tests++;
        if (de_n !== 1920) begin fails++; $display("FAIL default_de_count got %0d want 1920", de_n); end
        tests++;
        if (hs_n !== 288) begin fails++; $display("FAIL default_hsync_count got %0d want 288", hs_n); end
        tests++;
        if (ls_n !== 3) begin fails++; $display("FAIL default_line_starts got %0d want 3", ls_n); end
    endtask

    task automatic test_scale();
        cfg_t s = DEF;
        logic [46:0] e;
        s.xs = 1;
        s.ys = 1;
        en = 1'b0;
        drive_cfg(s);
        cfg_if.load = 1'b1;
        @(negedge clk);
        cfg_if.load = 1'b0;
        tests++;
        if (cfg_if.pending !== 1'b1) begin fails++; $display("FAIL scale_pending got %b want 1", cfg_if.pending); end
        @(negedge clk);
        tests++;
        if ({cfg_if.pending, cfg_if.err} !== 2'b00) begin
            fails++;
            $display("FAIL scale_applied_idle got %b want 00", {cfg_if.pending, cfg_if.err});
        end
        en = 1'b1;
        for (int k = 0; k < 3200; k++) begin
            @(negedge clk);
            e = exp_out(s, k % 800, k / 800);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL scale_k%0d got %h want %h", k, got, e);
            end
            if (k == 3 * 800 + 2) begin
                tests++;
                if (fb !== 19'd321) begin fails++; $display("FAIL scale_addr_x2_y3 got %0d want 321", fb); end
            end
            if (k == 800 + 5) begin
                tests++;
                if (fb !== 19'd2) begin fails++; $display("FAIL scale_addr_x5_y1 got %0d want 2", fb); end
            end
        end
    endtask

    task automatic test_midframe_load();
        int f1 = -1, f2 = -1;
        logic [46:0] e;
        logic pexp;
        en = 1'b0;
        drive_cfg(A);
        cfg_if.load = 1'b1;
        @(negedge clk);
        cfg_if.load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 480 + 168; k++) begin
            @(negedge clk);
            e = k < 480 ? exp_out(A, k % 16, (k / 16) % 10) : exp_out(B, (k - 480) % 12, ((k - 480) / 12) % 7);
            pexp = k >= 371 && k <= 478;
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL midload_k%0d got %h want %h", k, got, e);
            end
            tests++;
            if (cfg_if.pending !== pexp) begin
                fails++;
                $display("FAIL midload_pending_k%0d got %b want %b", k, cfg_if.pending, pexp);
            end
            if (k == 480 + 3 * 12 + 7) begin
                tests++;
                if (fb !== 19'd7) begin fails++; $display("FAIL midload_last_addr got %0d want 7", fb); end
            end
            if (k >= 480 && fs) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
            if (k == 370) begin
                drive_cfg(B);
                cfg_if.load = 1'b1;
            end else cfg_if.load = 1'b0;
        end
        tests++;
        if (f2 - f1 !== 84) begin fails++; $display("FAIL midload_frame_period got %0d want 84", f2 - f1); end
    endtask

    task automatic test_bad_load();
        cfg_t bad1 = B, bad2 = '{1024, 1, 1, 1, 1024, 1, 1, 1, 0, 0, 0, 0}, big = '{1024, 1, 1, 1, 512, 1, 1, 1, 0, 0, 0, 0};
        logic [46:0] e;
        bad1.hs = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            e = exp_out(B, j % 12, (j / 12) % 7);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL badload_k%0d got %h want %h", j, got, e);
            end
            if (j == 11 || j == 21) begin
                tests++;
                if ({cfg_if.err, cfg_if.pending} !== 2'b10) begin
                    fails++;
                    $display("FAIL badload_err_j%0d got %b want 10", j, {cfg_if.err, cfg_if.pending});
                end
            end
            if (j == 12 || j == 22 || j == 83) begin
                tests++;
                if ({cfg_if.err, cfg_if.pending} !== 2'b00) begin
                    fails++;
                    $display("FAIL badload_idle_j%0d got %b want 00", j, {cfg_if.err, cfg_if.pending});
                end
            end
            if (j == 31 || j == 32) begin
                tests++;
                if ({cfg_if.err, cfg_if.pending} !== 2'b01) begin
                    fails++;
                    $display("FAIL goodload_pending_j%0d got %b want 01", j, {cfg_if.err, cfg_if.pending});
                end
            end
            cfg_if.load = j == 10 || j == 20 || j == 30 || j == 31;
            drive_cfg(j == 10 ? bad1 : j == 20 ? bad2 : j == 30 ? big : B);
        end
    endtask

    task automatic test_reset_midframe();
        cfg_t c = B;
        logic [46:0] e;
        c.hpol = 1;
        c.vpol = 1;
        drive_cfg(c);
        cfg_if.load = 1'b1;
        @(negedge clk);
        cfg_if.load = 1'b0;
        tests++;
        if (cfg_if.pending !== 1'b1) begin fails++; $display("FAIL rstmid_pending_before got %b want 1", cfg_if.pending); end
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        tests++;
        if (got !== {5'b00011, 42'd0}) begin
            fails++;
            $display("FAIL rstmid_async_outputs got %h want %h", got, {5'b00011, 42'd0});
        end
        tests++;
        if (cfg_if.pending !== 1'b0) begin fails++; $display("FAIL rstmid_pending_cleared got %b want 0", cfg_if.pending); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 810; k++) begin
            @(negedge clk);
            e = exp_out(DEF, k % 800, k / 800);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL rstmid_restart_k%0d got %h want %h", k, got, e);
            end
        end
    endtask

    task automatic test_enable_pulse();
        logic [46:0] e;
        drive_cfg(D);
        cfg_if.load = 1'b1;
        @(negedge clk);
        cfg_if.load = 1'b0;
        tests++;
        if (cfg_if.pending !== 1'b1) begin fails++; $display("FAIL enpulse_pending got %b want 1", cfg_if.pending); end
        en = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (got !== 47'd0) begin fails++; $display("FAIL enpulse_idle got %h want 0", got); end
        tests++;
        if (cfg_if.pending !== 1'b0) begin fails++; $display("FAIL enpulse_applied got %b want 0", cfg_if.pending); end
        en = 1'b1;
        for (int k = 0; k < 168; k++) begin
            @(negedge clk);
            e = exp_out(D, k % 12, (k / 12) % 7);
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL enpulse_restart_k%0d got %h want %h", k, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_scale();
        test_midframe_load();
        test_bad_load();
        test_reset_midframe();
        test_enable_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
